// File: rtl/ram64x8_master_pkg.sv
// Shared constants and state encoding for the 64x8 RAM bus initiator.
package ram64x8_master_pkg;

  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEN_W   = 3;
  localparam int DEF_RD_WAIT = 1;
  localparam int RAM_DEPTH   = 64;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WDATA   = 3'd1;
  localparam state_t ST_WSTROBE = 3'd2;
  localparam state_t ST_RSTROBE = 3'd3;
  localparam state_t ST_RRESP   = 3'd4;

endpackage

// File: rtl/ram64x8_master_if.sv
// Datapath handshakes plus RAM pins of the 64x8 RAM initiator.
interface ram64x8_master_if;
  import ram64x8_master_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DEF_ADDR_W-1:0] req_addr;
  logic [DEF_LEN_W-1:0]  req_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DEF_DATA_W-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DEF_DATA_W-1:0] rd_data;
  logic                  ram_cs;
  logic                  ram_rw;
  logic [DEF_ADDR_W-1:0] ram_addr;
  logic [DEF_DATA_W-1:0] ram_wdata;
  logic [DEF_DATA_W-1:0] ram_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready, ram_rdata,
    output req_ready, wr_ready, rd_valid, rd_data, ram_cs, ram_rw, ram_addr, ram_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready, ram_rdata,
    input  req_ready, wr_ready, rd_valid, rd_data, ram_cs, ram_rw, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram64x8_master_addr_gen.sv
// RAM address register and remaining-beat counter for one request.
// Burst length honoured only when RAM_MASTER_BURST_EN is defined.
module ram_addr_gen
  import ram64x8_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  beats_left_r;
  logic [LEN_W-1:0]  len_eff_s;

`ifdef RAM_MASTER_BURST_EN
  assign len_eff_s = len;
`else
  // Single-beat build: the length field is deliberately dropped.
  logic unused_len_s;
  assign unused_len_s = ^len;
  assign len_eff_s    = {LEN_W{1'b0}};
`endif

  // Address and beat counter: load on acceptance, advance between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= {ADDR_W{1'b0}};
      beats_left_r <= {LEN_W{1'b0}};
    end else if (load) begin
      addr_r       <= start_addr;
      beats_left_r <= len_eff_s;
    end else if (step) begin
      addr_r       <= addr_r + ADDR_W'(1'b1);
      beats_left_r <= beats_left_r - LEN_W'(1'b1);
    end else begin
      addr_r       <= addr_r;
      beats_left_r <= beats_left_r;
    end
  end

  assign addr = addr_r;
  assign last = (beats_left_r == {LEN_W{1'b0}});

endmodule

// File: rtl/ram64x8_master.sv
// Bus initiator for the 64x8 single-port RAM: sequences chip-select and
// read/write strobes from request, write-data and read-response handshakes.
module ram64x8_master
  import ram64x8_master_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int RD_WAIT = DEF_RD_WAIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram64x8_master_if.master     bus
);

  localparam int                WAIT_W    = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT - 1);

  state_t              state_r;
  state_t              next_s;
  logic                load_s;
  logic                step_s;
  logic                last_s;
  logic                wait_done_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [ADDR_W-1:0]   addr_s;

  ram_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .step       (step_s),
    .start_addr (bus.req_addr),
    .len        (bus.req_len),
    .addr       (addr_s),
    .last       (last_s)
  );

  assign wait_done_s = (wait_cnt_r == WAIT_LAST);

  // Next-state decode plus address-generator controls.
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          load_s = 1'b1;
          next_s = bus.req_we ? ST_WDATA : ST_RSTROBE;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (bus.wr_valid) next_s = ST_WSTROBE;
        else              next_s = ST_WDATA;
      end
      ST_WSTROBE: begin
        if (last_s) begin
          next_s = ST_IDLE;
        end else begin
          step_s = 1'b1;
          next_s = ST_WDATA;
        end
      end
      ST_RSTROBE: begin
        if (wait_done_s) next_s = ST_RRESP;
        else             next_s = ST_RSTROBE;
      end
      ST_RRESP: begin
        if (!bus.rd_ready) begin
          next_s = ST_RRESP;
        end else if (last_s) begin
          next_s = ST_IDLE;
        end else begin
          step_s = 1'b1;
          next_s = ST_RSTROBE;
        end
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // State, read-strobe timer and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      rdata_r    <= {DATA_W{1'b0}};
    end else begin
      state_r <= next_s;
      if (state_r == ST_RSTROBE && !wait_done_s) wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
      else                                       wait_cnt_r <= {WAIT_W{1'b0}};
      if (state_r == ST_WDATA && bus.wr_valid)   wdata_r <= bus.wr_data;
      else                                       wdata_r <= wdata_r;
      // Capture at the end of the final strobe cycle; held through RRESP.
      if (state_r == ST_RSTROBE && wait_done_s)  rdata_r <= bus.ram_rdata;
      else                                       rdata_r <= rdata_r;
    end
  end

  assign bus.ram_cs    = (state_r == ST_WSTROBE) || (state_r == ST_RSTROBE);
  assign bus.ram_rw    = (state_r == ST_WSTROBE);
  assign bus.req_ready = (state_r == ST_IDLE);
  assign bus.wr_ready  = (state_r == ST_WDATA);
  assign bus.rd_valid  = (state_r == ST_RRESP);
  assign bus.ram_addr  = addr_s;
  assign bus.ram_wdata = wdata_r;
  assign bus.rd_data   = rdata_r;

endmodule

// File: tb/tb_ram64x8_master.sv
// Randomised self-checking bench for ram64x8_master against a behavioural
// memory model; burst expectations follow RAM_MASTER_BURST_EN.
module tb_ram64x8_master;
  import ram64x8_master_pkg::*;

  localparam int TB_RD_WAIT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram64x8_master_if bus();

  ram64x8_master #(.RD_WAIT(TB_RD_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks   = 0;
  int         n_errors   = 0;
  int         strobe_cnt = 0;
  logic [7:0] ram_mem [RAM_DEPTH];
  logic [7:0] ref_mem [RAM_DEPTH];
  logic [7:0] wbuf [8];

  // RAM macro model: level strobes sampled on the rising edge, async read.
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      strobe_cnt <= strobe_cnt + 1;
      if (bus.ram_rw) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end
  assign bus.ram_rdata = ram_mem[bus.ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input logic [2:0] len);
    int n;
    n = int'(len) + 1;
`ifndef RAM_MASTER_BURST_EN
    n = 1;
`endif
    return n;
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [2:0] len);
    int nb;
    int s0;
    int d;
    logic [5:0] ea;
    nb = beats_of(len);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_len = len;
    chk("wr_req_ready", bus.req_ready, 1);
    s0 = strobe_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = 6'($urandom); bus.req_len = 3'($urandom);
    for (int b = 0; b < nb; b++) begin
      d = $urandom_range(0, 2);
      repeat (d) begin
        chk("wr_wait_cs", bus.ram_cs, 0);
        @(negedge clk);
      end
      bus.wr_valid = 1'b1; bus.wr_data = wbuf[b];
      chk("wr_ready", bus.wr_ready, 1);
      @(negedge clk);
      bus.wr_valid = 1'b0; bus.wr_data = 8'($urandom);
      ea = a + 6'(b);
      chk("wr_cs", bus.ram_cs, 1);
      chk("wr_rw", bus.ram_rw, 1);
      chk("wr_addr", bus.ram_addr, ea);
      chk("wr_wdata", bus.ram_wdata, wbuf[b]);
      ref_mem[ea] = wbuf[b];
      @(negedge clk);
      chk("wr_strobe_end", bus.ram_cs, 0);
    end
    chk("wr_idle", bus.req_ready, 1);
    chk("wr_strobes", strobe_cnt - s0, nb);
  endtask

  task automatic do_read(input logic [5:0] a, input logic [2:0] len, input int hold);
    int nb;
    int s0;
    logic [5:0] ea;
    nb = beats_of(len);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; bus.req_len = len;
    chk("rd_req_ready", bus.req_ready, 1);
    s0 = strobe_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = 6'($urandom);
    bus.wr_valid  = 1'($urandom);
    for (int b = 0; b < nb; b++) begin
      ea = a + 6'(b);
      repeat (TB_RD_WAIT) begin
        chk("rd_cs", bus.ram_cs, 1);
        chk("rd_rw", bus.ram_rw, 0);
        chk("rd_addr", bus.ram_addr, ea);
        @(negedge clk);
      end
      repeat (hold) begin
        chk("rd_hold_valid", bus.rd_valid, 1);
        chk("rd_hold_data", bus.rd_data, ref_mem[ea]);
        chk("rd_hold_cs", bus.ram_cs, 0);
        @(negedge clk);
      end
      bus.rd_ready = 1'b1;
      chk("rd_valid", bus.rd_valid, 1);
      chk("rd_data", bus.rd_data, ref_mem[ea]);
      @(negedge clk);
      bus.rd_ready = 1'b0;
    end
    bus.wr_valid = 1'b0;
    chk("rd_idle", bus.req_ready, 1);
    chk("rd_valid_low", bus.rd_valid, 0);
    chk("rd_strobes", strobe_cnt - s0, nb * TB_RD_WAIT);
  endtask

  initial begin
    int s0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 6'd0; bus.req_len = 3'd0;
    bus.wr_valid  = 1'b0; bus.wr_data = 8'd0; bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cs", bus.ram_cs, 0);
    chk("rst_rw", bus.ram_rw, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    wbuf[0] = 8'hA5;
    do_write(6'h05, 3'd0);
    do_read(6'h05, 3'd0, 0);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(6'h3E, 3'd3);
    do_read(6'h3E, 3'd3, 0);
    do_read(6'h3E, 3'd0, 5);

    for (int i = 0; i < RAM_DEPTH; i++) begin
      wbuf[0] = 8'($urandom);
      do_write(6'(i), 3'd0);
    end

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(6'($urandom), 3'($urandom));
      else                           do_read(6'($urandom), 3'($urandom), $urandom_range(0, 3));
    end

    // Reset during the second beat of a four-beat write.
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 6'h20; bus.req_len = 3'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_data = wbuf[0];
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk("rstb_beat0_cs", bus.ram_cs, 1);
    ref_mem[6'h20] = wbuf[0];
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_data = wbuf[1];
    @(negedge clk);
    bus.wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstb_cs_drop", bus.ram_cs, 0);
    chk("rstb_rw_drop", bus.ram_rw, 0);
    chk("rstb_addr", bus.ram_addr, 0);
    s0 = strobe_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      bus.wr_valid = 1'($urandom); bus.rd_ready = 1'($urandom);
      @(negedge clk);
      chk("rstb_no_strobe", bus.ram_cs, 0);
      chk("rstb_idle", bus.req_ready, 1);
    end
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    chk("rstb_strobes", strobe_cnt - s0, 0);
    do_read(6'h20, 3'd0, 1);

    for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
    do_write(6'h10, 3'd7);
    do_read(6'h10, 3'd7, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
